// File: rtl/adder_arbiter.sv
// Round-robin arbiter that shares one n-bit adder among NREQ requesters.
// It runs one operation at a time and holds the registered sum until the consumer takes it.
module adder_arbiter #(
    parameter  int n    = 16,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [n-1:0]      rsp_sum,
    output logic              rsp_carry,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [n-1:0]   op_a;
    logic [n-1:0]   op_b;
    logic [IDW-1:0] op_id;

    logic           found;
    logic [IDW-1:0] winner;
    logic [IDW:0]   cand;
    logic [IDW:0]   ptr_nxt;
    logic [n-1:0]   win_a;
    logic [n-1:0]   win_b;
    logic [n:0]     sum_full;

    // Search upward from ptr with wrap; the first requester found wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= NREQ_W)
                cand = cand - NREQ_W;
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                win_a = req_a[i*n +: n];
                win_b = req_b[i*n +: n];
            end
        end
        ptr_nxt = {1'b0, winner} + 1'b1;
        if (ptr_nxt == NREQ_W)
            ptr_nxt = '0;
    end

    // The grant is combinational, so it is also gated by rst to stay low while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && found)
            req_ready[winner] = 1'b1;
    end

    assign sum_full = {1'b0, op_a} + {1'b0, op_b};
    assign busy     = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a  <= win_a;
                        op_b  <= win_b;
                        op_id <= winner;
                        ptr   <= ptr_nxt[IDW-1:0];
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_full[n-1:0];
                    rsp_carry <= sum_full[n];
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one n-bit adder datapath among NREQ requesters. It accepts one operand pair at a time through a valid/ready handshake, then registers the sum and carry-out. The result is held on a single response port until the consumer accepts it. It sits between multiple issuing units (e.g. PC/branch-target logic, address generation) and a single instance of the team's behavioural adder.

## Interface
- n, 16, operand and sum width in bits
- NREQ, 4, number of requesters; supported range 2..8; IDW = $clog2(NREQ)

- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- req_valid  in  NREQ  bit i: requester i presents an operand pair
- req_a  in  NREQ*n  packed; requester i operand A at [i*n +: n]
- req_b  in  NREQ*n  packed; requester i operand B at [i*n +: n]
- req_ready  out  NREQ  one-hot grant; bit i high means requester i is accepted this cycle
- rsp_valid  out  1  response holds a valid result
- rsp_ready  in  1  consumer accepts the response
- rsp_sum  out  n  (a + b) mod 2^n
- rsp_carry  out  1  bit n of the (n+1)-bit sum a + b
- rsp_id  out  IDW  index of the requester that produced the response
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching upward from ptr, wrapping NREQ-1 to 0.
  - req_ready[winner]=1 combinationally in the same cycle. The handshake completes on that edge.
  - On that edge: latch req_a/req_b slice of winner and the winner index; ptr <= (winner+1) mod NREQ; go to EXEC.
  - If no req_valid is high: stay in IDLE, req_ready = 0.
- EXEC:
  - The adder computes on the latched operands.
  - On the edge: rsp_sum, rsp_carry and rsp_id are registered; rsp_valid <= 1; go to HOLD.
- HOLD:
  - rsp_valid=1.
  - If rsp_ready=1 on an edge: rsp_valid <= 0 and go to IDLE. Otherwise stay, with all rsp_* outputs held stable.
- req_ready is 0 in EXEC and HOLD. A new request is never accepted before the previous response is consumed.
- req_valid bits with no grant are ignored. Requesters keep req_valid and operands asserted until they see their req_ready bit.
- req_valid -> req_ready is a combinational path. A requester must not derive req_valid from req_ready.
- Operands may change after grant; the latched copy is used.
- Arithmetic: the internal sum is n+1 bits wide. rsp_sum = low n bits, rsp_carry = MSB. Unsigned; no overflow flag.

## Timing
- Reset values: state IDLE, ptr 0, rsp_valid 0, rsp_sum 0, rsp_carry 0, rsp_id 0, busy 0, req_ready 0.
- Reset mid-operation (EXEC or HOLD): the pending result is discarded. Outputs go to reset values immediately (asynchronously), without waiting for a clock edge.
- Latency: grant edge T -> rsp_valid high after edge T+1 (visible in cycle T+1 to T+2) -> earliest accept at edge T+2 -> earliest next grant at edge T+3.
- Throughput: at most one operation per 3 cycles with rsp_ready held high.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by round-robin.
- Starvation: with continuous requests, every requester is granted within NREQ operations.
- ptr wraps from NREQ-1 to 0. ptr is updated only on a grant.
- busy rises on the grant edge and falls on the response-accept edge.

## Test plan
- Reset: hold rst=1, then pulse rst while in HOLD with rsp_ready=0 -> rsp_valid, rsp_sum, rsp_carry, rsp_id, busy and req_ready all go to 0 without a clock edge; first request after release is granted with ptr=0 priority.
- Single request: req_valid=0001, a0=0x1234, b0=0x0101, rsp_ready=1 -> req_ready=0001 in the same cycle; rsp_valid=1 two edges later with rsp_sum=0x1335, rsp_carry=0, rsp_id=0.
- Carry: requester 2, a=0xFFFF, b=0x0002 -> rsp_sum=0x0001, rsp_carry=1, rsp_id=2. Also a=0x8000, b=0x8000 -> rsp_sum=0x0000, rsp_carry=1.
- Round-robin fairness: req_valid=1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 with grants exactly 3 cycles apart.
- Wrap and skip: after requester 1 is granted (ptr=2), only req_valid=0011 present -> grant goes to requester 0, then to requester 1.
- Backpressure: hold rsp_ready=0 for 5 cycles while in HOLD with req_valid=1111 -> rsp_valid stays 1, rsp_sum/rsp_id stay stable, req_ready=0000 throughout; after rsp_ready=1, return to IDLE and grant the next requester in round-robin order.
